booth_mul_scheduler: RTL and testbench
======================================

// Module: booth_mul_scheduler
// PURPOSE
//   Shares one sequential Booth multiplier between NREQ requesters.
//   - Arbitrates requests round-robin and captures the winner's operands.
//   - Holds the multiplier start/M/Q until the multiplier raises valid.
//   - Returns the signed product tagged with the requester id.
//   - Sits between client blocks and the single booths_multiplier instance.
// PARAMETERS
//   NREQ    4   number of requesters (2..8)
//   WIDTH   8   operand width; product is 2*WIDTH
//   TIMEOUT 31  max RUN cycles waiting for mul_valid; must be >= WIDTH+2
// PORTS
//   clk        in   1            single clock, rising edge
//   reset      in   1            asynchronous, active-low reset
//   req        in   NREQ         request per client; held with operands until gnt
//   req_m      in   NREQ*WIDTH   signed multiplicand per client; slice i = client i
//   req_q      in   NREQ*WIDTH   signed multiplier per client
//   gnt        out  NREQ         one-hot, 1-cycle pulse: operands accepted
//   rsp_valid  out  1            1-cycle pulse: result available
//   rsp_id     out  $clog2(NREQ) index of the client owning the result
//   rsp_data   out  2*WIDTH      signed product (0 on error)
//   rsp_err    out  1            with rsp_valid: multiplier timed out
//   busy       out  1            high in any state other than IDLE
//   mul_start  out  1            to multiplier start; level, held through a job
//   mul_m      out  WIDTH        to multiplier M
//   mul_q      out  WIDTH        to multiplier Q
//   mul_valid  in   1            from multiplier valid
//   mul_acc    in   2*WIDTH      from multiplier Acc
// BEHAVIOUR
//   Reset (reset=0, asynchronous)
//   - All outputs go to 0, state IDLE, RR pointer to 0, timeout counter to 0.
//   - Reset mid-job drops the in-flight job silently: no rsp_valid, mul_start=0 at once.
//   Registered outputs
//   - All outputs are registered.
//   FSM: IDLE -> RUN -> GAP -> IDLE
//   - IDLE, any req bit set at an edge:
//     - Pick the winner round-robin, searching from ptr upward with wrap. After reset ptr=0, so client 0 has first priority.
//     - Next cycle: gnt[w]=1 for 1 cycle, mul_m/mul_q = req_m[w]/req_q[w], mul_start=1, rsp_id=w.
//     - ptr = (w+1) mod NREQ. State -> RUN.
//   - RUN:
//     - mul_start, mul_m and mul_q stay stable. The counter increments each cycle.
//     - Edge with mul_valid=1: rsp_data=mul_acc, rsp_valid=1, rsp_err=0, mul_start=0 -> GAP.
//     - Counter reaches TIMEOUT with no mul_valid: rsp_valid=1, rsp_err=1, rsp_data=0, mul_start=0 -> GAP.
//     - mul_valid on the same edge as the timeout: valid wins (no error).
//   - GAP:
//     - One cycle with mul_start=0 so the multiplier returns to idle.
//     - rsp_valid and rsp_err clear. Counter clears. State -> IDLE.
//   Handshake rules
//   - A client deasserts req in the cycle after it sees gnt.
//   - req still high when IDLE is re-entered counts as a new request.
//   - req is ignored outside IDLE. Pending requests are never lost; they wait.
//   - Minimum spacing between jobs: the GAP and IDLE cycles.
//   Arithmetic and result hold
//   - Operands and product pass through unmodified (two's complement); no widening or saturation here.
//   - rsp_data and rsp_id hold their values until the next response or reset.
//   Contention
//   - All clients requesting together are served in strict order ptr, ptr+1, ... (wrap).
// CONFIGURATION
//   ZERO_BYPASS_EN
//   - Defined: in IDLE, a winner with req_m==0 or req_q==0 skips the multiplier.
//     - gnt pulses and the result is returned directly: rsp_valid=1, rsp_data=0, rsp_err=0 in the cycle after gnt.
//     - Then GAP as normal. mul_start is never asserted for that job.
//   - Undefined: every job goes through the multiplier, including zero operands.
// TESTING
//   1. req[0], M=45, Q=10 -> gnt[0] pulse; rsp_valid, rsp_id=0, rsp_data=450, rsp_err=0.
//   2. req[3:0] together: (56,79), (127,127), (-45,10), (-128,-128)
//      -> grants in order 0,1,2,3; results 4424, 16129, -450, 16384.
//   3. req[0] and req[2] held high continuously -> grants alternate 0,2,0,2; client 1 and 3 never granted.
//   4. mul_valid stubbed to 0 -> rsp_valid exactly TIMEOUT=31 cycles after mul_start rises; rsp_err=1, rsp_data=0.
//   5. reset driven low mid-RUN -> all outputs 0 immediately, no rsp_valid;
//      after release, req[1:0]=2'b11 -> gnt[0] first.
//   6. ZERO_BYPASS_EN, M=0, Q=77 -> rsp_data=0 one cycle after gnt, mul_start stays 0;
//      without the macro: same result via the multiplier.

Source files
------------

// File: rtl/booth_mul_scheduler_if.sv
// booth_mul_scheduler_if
//   Bundles the client request/response bus and the multiplier-side signals
//   of booth_mul_scheduler.
//   slave  : the scheduler (consumes req/req_m/req_q/mul_valid/mul_acc)
//   master : the environment (clients plus the shared multiplier)
//   Signals: req, req_m, req_q, gnt, rsp_valid, rsp_id, rsp_data, rsp_err,
//            busy, mul_start, mul_m, mul_q, mul_valid, mul_acc
interface booth_mul_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_m;
    logic [NREQ*WIDTH-1:0] req_q;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_m;
    logic [WIDTH-1:0]      mul_q;
    logic                  mul_valid;
    logic [2*WIDTH-1:0]    mul_acc;

    modport slave (
        input  req, req_m, req_q, mul_valid, mul_acc,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               mul_start, mul_m, mul_q
    );

    modport master (
        output req, req_m, req_q, mul_valid, mul_acc,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               mul_start, mul_m, mul_q
    );
endinterface

// File: rtl/booth_mul_scheduler.sv
// booth_mul_scheduler
//   Shares one sequential Booth multiplier between NREQ requesters.
//   Round-robin arbitration in IDLE, holds start/M/Q while the multiplier
//   runs, returns the signed product tagged with the requester id, and
//   reports a timeout error if the multiplier never raises valid.
// Ports
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous reset, active low
//   io_bus   : booth_mul_scheduler_if.slave (client bus + multiplier side)
// Parameters
//   NREQ (2..8), WIDTH (operand width), TIMEOUT (RUN cycles, >= WIDTH+2)
// Build option
//   ZERO_BYPASS_EN : jobs with a zero operand skip the multiplier and return
//                    0 the cycle after the grant.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for any req; arbitrates at the next edge
// RUN    | multiplier started, waiting for mul_valid or timeout
// BYP    | zero-operand job, result returned without the multiplier
// GAP    | one cycle with mul_start low so the multiplier returns to idle
module booth_mul_scheduler #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 31
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    booth_mul_scheduler_if.slave  io_bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BYP, S_GAP} state_t;

    state_t             r_state,     w_state_nxt;
    logic [IW-1:0]      r_ptr,       w_ptr_nxt;
    logic [CW-1:0]      r_cnt,       w_cnt_nxt;
    logic [NREQ-1:0]    r_gnt,       w_gnt_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic               r_rsp_err,   w_rsp_err_nxt;
    logic [IW-1:0]      r_rsp_id,    w_rsp_id_nxt;
    logic [2*WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic               r_mul_start, w_mul_start_nxt;
    logic [WIDTH-1:0]   r_mul_m,     w_mul_m_nxt;
    logic [WIDTH-1:0]   r_mul_q,     w_mul_q_nxt;

    logic [2*NREQ-1:0]  w_req2;
    logic [NREQ-1:0]    w_rot;
    logic               w_found;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_win;
    logic [WIDTH-1:0]   w_win_m;
    logic [WIDTH-1:0]   w_win_q;
`ifdef ZERO_BYPASS_EN
    logic               w_win_zero;
`endif

    // Rotate the request vector so bit 0 is the client at r_ptr; the first
    // set bit is the offset of the winner from the pointer.
    always_comb begin
        w_req2  = {io_bus.req, io_bus.req};
        w_rot   = NREQ'(w_req2 >> r_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_win = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
        w_win_m = '0;
        w_win_q = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) begin
                w_win_m = io_bus.req_m[i*WIDTH +: WIDTH];
                w_win_q = io_bus.req_q[i*WIDTH +: WIDTH];
            end
        end
`ifdef ZERO_BYPASS_EN
        w_win_zero = (w_win_m == '0) || (w_win_q == '0);
`endif
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = '0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_data_nxt  = r_rsp_data;
        w_mul_start_nxt = r_mul_start;
        w_mul_m_nxt     = r_mul_m;
        w_mul_q_nxt     = r_mul_q;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt    = NREQ'(1) << w_win;
                    w_rsp_id_nxt = w_win;
                    w_ptr_nxt    = (w_win == IW'(NREQ-1)) ? '0 : w_win + IW'(1);
`ifdef ZERO_BYPASS_EN
                    if (w_win_zero) begin
                        w_state_nxt = S_BYP;
                    end else begin
                        w_mul_start_nxt = 1'b1;
                        w_mul_m_nxt     = w_win_m;
                        w_mul_q_nxt     = w_win_q;
                        w_state_nxt     = S_RUN;
                    end
`else
                    w_mul_start_nxt = 1'b1;
                    w_mul_m_nxt     = w_win_m;
                    w_mul_q_nxt     = w_win_q;
                    w_state_nxt     = S_RUN;
`endif
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // Valid is tested first so it wins over a coincident timeout.
                if (io_bus.mul_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = io_bus.mul_acc;
                    w_mul_start_nxt = 1'b0;
                    w_state_nxt     = S_GAP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_data_nxt  = '0;
                    w_mul_start_nxt = 1'b0;
                    w_state_nxt     = S_GAP;
                end
            end
            S_BYP: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = '0;
                w_state_nxt     = S_GAP;
            end
            S_GAP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_mul_start <= 1'b0;
            r_mul_m     <= '0;
            r_mul_q     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_mul_m     <= w_mul_m_nxt;
            r_mul_q     <= w_mul_q_nxt;
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.rsp_id    = r_rsp_id;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.mul_start = r_mul_start;
    assign io_bus.mul_m     = r_mul_m;
    assign io_bus.mul_q     = r_mul_q;
    assign io_bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_booth_mul_scheduler.sv
module tb_booth_mul_scheduler;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 31;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    booth_mul_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

    booth_mul_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural stand-in for the shared multiplier: valid (with the
    // product) appears cur_lat cycles after start rises, held until start drops.
    int mul_lat  = 9;
    bit mul_stub = 1'b0;
    bit rand_lat = 1'b0;
    int mcnt     = 0;
    int cur_lat  = 1;
    int pa, pb;
    always @(negedge clk) begin
        if (!bus.mul_start) begin
            mcnt          = 0;
            bus.mul_valid = 1'b0;
            bus.mul_acc   = '0;
        end else begin
            if (mcnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 20)) : mul_lat;
            mcnt++;
            if (!mul_stub && mcnt >= cur_lat) begin
                pa            = int'($signed(bus.mul_m));
                pb            = int'($signed(bus.mul_q));
                bus.mul_valid = 1'b1;
                bus.mul_acc   = 16'(pa * pb);
            end
        end
    end

    logic signed [7:0] op_m [NREQ];
    logic signed [7:0] op_q [NREQ];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic push_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_m[i*WIDTH +: WIDTH] = op_m[i];
            bus.req_q[i*WIDTH +: WIDTH] = op_q[i];
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        mul_stub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string name, input int budget, output logic [NREQ-1:0] g);
        g = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                g = bus.gnt;
                return;
            end
        end
        fail(name, "no grant within cycle budget");
    endtask

    // Returns the number of negedges from the call until rsp_valid is seen.
    task automatic wait_rsp(input string name, input int budget, output int cycles, output bit saw_start);
        cycles    = 0;
        saw_start = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.mul_start) saw_start = 1'b1;
            if (bus.rsp_valid) return;
        end
        fail(name, "no response within cycle budget");
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        fail(name, "busy never cleared");
    endtask

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'h80;
            2:       return 8'h7F;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    typedef struct packed {
        logic [NREQ-1:0]    req;
        logic [NREQ*8-1:0]  m;
        logic [NREQ*8-1:0]  q;
        logic [2:0]         n;
        logic [NREQ*2-1:0]  ids;
        logic [NREQ*16-1:0] data;
    } vec_t;

    vec_t vecs [6];

    logic [NREQ-1:0]   g;
    logic [NREQ-1:0]   edge_req;
    logic              edge_busy;
    logic signed [7:0] edge_m [NREQ];
    logic signed [7:0] edge_q [NREQ];
    int                cyc_cnt;
    bit                saw;
    int                k_g, k_r, win, model_ptr, exp_id, exp_data, n_jobs, n_rsp;
    bit                pending;

    initial begin
        // req, m (client3..0), q (client3..0), count, grant order ids, products
        vecs[0] = '{req: 4'b0001, m: {8'(0), 8'(0), 8'(0), 8'(45)}, q: {8'(0), 8'(0), 8'(0), 8'(10)},
                    n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd0}, data: {16'(0), 16'(0), 16'(0), 16'(450)}};
        vecs[1] = '{req: 4'b1111, m: {8'(-128), 8'(-45), 8'(127), 8'(56)}, q: {8'(-128), 8'(10), 8'(127), 8'(79)},
                    n: 3'd4, ids: {2'd3, 2'd2, 2'd1, 2'd0}, data: {16'(16384), 16'(-450), 16'(16129), 16'(4424)}};
        vecs[2] = '{req: 4'b1010, m: {8'(127), 8'(0), 8'(-1), 8'(0)}, q: {8'(-128), 8'(0), 8'(-1), 8'(0)},
                    n: 3'd2, ids: {2'd0, 2'd0, 2'd3, 2'd1}, data: {16'(0), 16'(0), 16'(-16256), 16'(1)}};
        vecs[3] = '{req: 4'b0100, m: {8'(0), 8'(-128), 8'(0), 8'(0)}, q: {8'(0), 8'(127), 8'(0), 8'(0)},
                    n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd2}, data: {16'(0), 16'(0), 16'(0), 16'(-16256)}};
        vecs[4] = '{req: 4'b1001, m: {8'(100), 8'(0), 8'(0), 8'(-7)}, q: {8'(-3), 8'(0), 8'(0), 8'(9)},
                    n: 3'd2, ids: {2'd0, 2'd0, 2'd3, 2'd0}, data: {16'(0), 16'(0), 16'(-300), 16'(-63)}};
        vecs[5] = '{req: 4'b0110, m: {8'(0), 8'(-128), 8'(0), 8'(0)}, q: {8'(0), 8'(-1), 8'(77), 8'(0)},
                    n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd1}, data: {16'(0), 16'(0), 16'(128), 16'(0)}};

        for (int i = 0; i < NREQ; i++) begin
            op_m[i] = '0;
            op_q[i] = '0;
        end
        push_ops();
        bus.req = '0;

        // Reset state
        do_reset();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_mul_mq", {bus.mul_m, bus.mul_q}, 0);

        // Table-driven vectors, each from a fresh reset (pointer at 0)
        mul_lat = 9;
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < NREQ; i++) begin
                op_m[i] = vecs[v].m[i*8 +: 8];
                op_q[i] = vecs[v].q[i*8 +: 8];
            end
            push_ops();
            bus.req = vecs[v].req;
            k_g = 0;
            k_r = 0;
            for (int c = 0; c < 300 && k_r < int'(vecs[v].n); c++) begin
                @(negedge clk);
                if (bus.gnt != '0) begin
                    if (k_g < int'(vecs[v].n))
                        chk($sformatf("vec%0d_gnt%0d", v, k_g), bus.gnt, 64'(1) << vecs[v].ids[k_g*2 +: 2]);
                    else
                        fail($sformatf("vec%0d_extra_gnt", v), "grant beyond expected count");
                    bus.req = bus.req & ~bus.gnt;
                    k_g++;
                end
                if (bus.rsp_valid) begin
                    chk($sformatf("vec%0d_id%0d", v, k_r), bus.rsp_id, vecs[v].ids[k_r*2 +: 2]);
                    chk($sformatf("vec%0d_data%0d", v, k_r), $signed(bus.rsp_data), $signed(vecs[v].data[k_r*16 +: 16]));
                    chk($sformatf("vec%0d_err%0d", v, k_r), bus.rsp_err, 0);
                    k_r++;
                end
            end
            if (k_r < int'(vecs[v].n)) fail($sformatf("vec%0d_done", v), "responses missing");
            wait_idle($sformatf("vec%0d_idle", v), 10);
        end

        // Two clients held high: grants alternate 0,2,0,2
        do_reset();
        op_m[0] = 8'(3); op_q[0] = 8'(4);
        op_m[2] = 8'(5); op_q[2] = 8'(6);
        push_ops();
        bus.req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_gnt($sformatf("rr_wait%0d", k), 100, g);
            chk($sformatf("rr_alt%0d", k), g, 64'(1) << ((k % 2) * 2));
        end
        bus.req = '0;
        wait_idle("rr_idle", 100);

        // Timeout: multiplier never answers; also valid on the timeout edge
        for (int t = 0; t < 3; t++) begin
            do_reset();
            mul_stub = (t == 0);
            mul_lat  = (t == 1) ? TIMEOUT : TIMEOUT + 1;
            op_m[0] = 8'(3); op_q[0] = 8'(5);
            push_ops();
            bus.req = 4'b0001;
            wait_gnt($sformatf("to%0d_gnt", t), 10, g);
            bus.req = '0;
            chk($sformatf("to%0d_start", t), bus.mul_start, 1);
            wait_rsp($sformatf("to%0d_rsp", t), 60, cyc_cnt, saw);
            chk($sformatf("to%0d_latency", t), cyc_cnt, TIMEOUT);
            chk($sformatf("to%0d_err", t), bus.rsp_err, (t == 1) ? 0 : 1);
            chk($sformatf("to%0d_data", t), $signed(bus.rsp_data), (t == 1) ? 15 : 0);
            chk($sformatf("to%0d_start_drop", t), bus.mul_start, 0);
            @(negedge clk);
            chk($sformatf("to%0d_pulse", t), {bus.rsp_valid, bus.rsp_err}, 0);
            chk($sformatf("to%0d_hold", t), $signed(bus.rsp_data), (t == 1) ? 15 : 0);
        end
        mul_stub = 1'b0;

        // Reset mid-RUN drops the job; client 0 first afterwards
        do_reset();
        mul_lat = 20;
        op_m[0] = 8'(6); op_q[0] = 8'(7);
        push_ops();
        bus.req = 4'b0001;
        wait_gnt("rstrun_gnt", 10, g);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstrun_start", bus.mul_start, 0);
        chk("rstrun_busy", bus.busy, 0);
        chk("rstrun_id_mq", {bus.rsp_id, bus.mul_m, bus.mul_q}, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstrun_norsp%0d", c), bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        op_m[0] = 8'(2); op_q[0] = 8'(3);
        op_m[1] = 8'(4); op_q[1] = 8'(5);
        push_ops();
        bus.req = 4'b0011;
        wait_gnt("rstrun_gnt_a", 10, g);
        chk("rstrun_first", g, 1);
        bus.req = bus.req & ~g;
        wait_rsp("rstrun_rsp_a", 40, cyc_cnt, saw);
        chk("rstrun_data_a", $signed(bus.rsp_data), 6);
        wait_gnt("rstrun_gnt_b", 10, g);
        chk("rstrun_second", g, 2);
        bus.req = '0;
        wait_rsp("rstrun_rsp_b", 40, cyc_cnt, saw);
        chk("rstrun_data_b", $signed(bus.rsp_data), 20);
        chk("rstrun_id_b", bus.rsp_id, 1);

        // Zero operand job
        do_reset();
        mul_lat = 10;
        op_m[0] = 8'(0); op_q[0] = 8'(77);
        push_ops();
        bus.req = 4'b0001;
        wait_gnt("zero_gnt", 10, g);
        bus.req = '0;
        saw = bus.mul_start;
        wait_rsp("zero_rsp", 40, cyc_cnt, pending);
        saw = saw | pending;
        chk("zero_data", bus.rsp_data, 0);
        chk("zero_err", bus.rsp_err, 0);
`ifdef ZERO_BYPASS_EN
        chk("zero_latency", cyc_cnt, 1);
        chk("zero_no_start", saw, 0);
`else
        chk("zero_latency", cyc_cnt, 10);
        chk("zero_start", saw, 1);
`endif
        wait_idle("zero_idle", 10);

        // Random traffic against a round-robin/product reference model
        do_reset();
        rand_lat  = 1'b1;
        model_ptr = 0;
        pending   = 1'b0;
        n_jobs    = 0;
        n_rsp     = 0;
        edge_req  = bus.req;
        edge_busy = bus.busy;
        for (int i = 0; i < NREQ; i++) begin
            edge_m[i] = op_m[i];
            edge_q[i] = op_q[i];
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g = bus.gnt;
            if (g != '0) begin
                chk("rand_gnt_idle", edge_busy, 0);
                win = -1;
                for (int i = 0; i < NREQ; i++)
                    if (win < 0 && edge_req[(model_ptr + i) % NREQ]) win = (model_ptr + i) % NREQ;
                if (win < 0) begin
                    fail("rand_gnt_spurious", "grant with no request pending");
                end else begin
                    chk("rand_gnt_winner", g, 64'(1) << win);
                    chk("rand_overlap", pending, 0);
                    model_ptr = (win + 1) % NREQ;
                    exp_id    = win;
                    exp_data  = int'(edge_m[win]) * int'(edge_q[win]);
                    pending   = 1'b1;
                    bus.req[win] = 1'b0;
                    n_jobs++;
                end
            end else if (!edge_busy && edge_req != '0) begin
                fail("rand_gnt_missing", "idle with request but no grant");
            end
            if (bus.rsp_valid) begin
                chk("rand_rsp_expected", pending, 1);
                chk("rand_rsp_id", bus.rsp_id, exp_id);
                chk("rand_rsp_data", $signed(bus.rsp_data), exp_data);
                chk("rand_rsp_err", bus.rsp_err, 0);
                pending = 1'b0;
                n_rsp++;
            end
            if (cyc < 2800) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                        op_m[i]    = rnd_op();
                        op_q[i]    = rnd_op();
                        bus.req[i] = 1'b1;
                    end
                end
            end
            push_ops();
            edge_req  = bus.req;
            edge_busy = bus.busy;
            for (int i = 0; i < NREQ; i++) begin
                edge_m[i] = op_m[i];
                edge_q[i] = op_q[i];
            end
        end
        chk("rand_drained", pending, 0);
        chk("rand_all_answered", n_rsp, n_jobs);
        rand_lat = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
